// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared datapath bus constants and word type
package bus_pkg;

    // Width of the shared datapath bus, also used by the special registers.
    localparam int BUS_WIDTH  = 16;

    // Default capture FIFO depth for bus readers (power of 2, at least 2).
    localparam int FIFO_DEPTH = 4;

    typedef logic [BUS_WIDTH-1:0] bus_word_t;

endpackage

// File: rtl/bus_reader_store.sv
// rtl/bus_reader_store.sv - register array with one sync write and one async read port
module bus_reader_store #(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    // Contents are deliberately not reset; validity is tracked by the owner's count.
    logic [WIDTH-1:0] mem [DEPTH];

    // Synchronous write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Asynchronous read port so the head word falls through without a cycle of latency.
    assign rdata = mem[raddr];

endmodule

// File: rtl/bus_reader.sv
// rtl/bus_reader.sv - samples the shared bus on load strobe into a FWFT FIFO
module bus_reader
    import bus_pkg::*;
#(
    parameter  int WIDTH = BUS_WIDTH,
    parameter  int DEPTH = FIFO_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] bus,
    input  logic             l,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty,
    output logic             overflow,
    input  logic             clr_ovf
);

    localparam int CW = AW + 1;

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push;
    logic             pop;
    logic             drop;
    logic             store_we;
    logic [WIDTH-1:0] head_word;

    // Occupancy flags come from the counter, so a full buffer and an empty
    // buffer never alias the way equal pointers would.
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // A pop frees a slot in the same cycle, so a full buffer still accepts a
    // capture when the consumer is draining.
    assign pop   = out_valid && out_ready;
    assign push  = l && (!full || pop);
    assign drop  = l && full && !pop;

    // Nothing lands in storage while reset is held, even if a strobe arrives.
    assign store_we = push && !reset;

    bus_reader_store #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_store (
        .clk   (clk),
        .we    (store_we),
        .waddr (wr_ptr),
        .wdata (bus),
        .raddr (rd_ptr),
        .rdata (head_word)
    );

    // Pointer, occupancy and sticky overflow bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            // A drop in the same cycle as a clear must leave the flag set.
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    // Head-of-queue presentation; the data bus reads zero when nothing is held
    // so stale storage never shows on the output.
    always_comb begin
        out_valid = !empty;
        out_data  = '0;
        if (!empty) begin
            out_data = head_word;
        end
    end

endmodule

// File: tb/tb_bus_reader.sv
// tb/tb_bus_reader.sv - randomized scoreboard bench for bus_reader
module tb_bus_reader;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] bus;
    logic             l;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic [AW:0]      count;
    logic             full;
    logic             empty;
    logic             overflow;
    logic             clr_ovf;

    int checks = 0;
    int errors = 0;
    bit mon_en = 0;

    // Reference contents (updated at the clock edge) and the scoreboard of
    // words still expected on the output (retired by the monitor).
    logic [WIDTH-1:0] ref_q[$];
    logic [WIDTH-1:0] sb_q[$];
    logic             model_ovf;

    bus_reader #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .l         (l),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, then advance the reference at the edge.
    task automatic cyc(input logic rst, input logic li, input logic [WIDTH-1:0] b,
                       input logic rdy, input logic clr);
        bit do_pop, do_push, is_full;
        reset     = rst;
        l         = li;
        bus       = b;
        out_ready = rdy;
        clr_ovf   = clr;
        @(posedge clk);
        if (rst) begin
            ref_q.delete();
            sb_q.delete();
            model_ovf = 1'b0;
        end else begin
            is_full = (ref_q.size() == DEPTH);
            do_pop  = (ref_q.size() > 0) && rdy;
            do_push = li && (!is_full || do_pop);
            if (do_pop) void'(ref_q.pop_front());
            if (do_push) begin
                ref_q.push_back(b);
                sb_q.push_back(b);
            end
            if (li && is_full && !do_pop) model_ovf = 1'b1;
            else if (clr) model_ovf = 1'b0;
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 16'h0, 0, 0);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 16'h0, 1, 0);
    endtask

    // Monitor: compare every visible output against the reference and retire
    // scoreboard entries on each accepted handshake.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("count", 32'(count), 32'(ref_q.size()));
            chk("out_valid", 32'(out_valid), 32'(ref_q.size() != 0));
            chk("full", 32'(full), 32'(ref_q.size() == DEPTH));
            chk("empty", 32'(empty), 32'(ref_q.size() == 0));
            chk("overflow", 32'(overflow), 32'(model_ovf));
            if (out_valid) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_underrun actual=valid_word required=no_word at %0t", $time);
                end else begin
                    chk("out_data", 32'(out_data), 32'(sb_q[0]));
                    if (out_ready && !reset) void'(sb_q.pop_front());
                end
            end else begin
                chk("idle_data", 32'(out_data), 32'h0);
            end
        end
    end

    initial begin
        reset = 1'b1; l = 1'b0; bus = '0; out_ready = 1'b0; clr_ovf = 1'b0;
        model_ovf = 1'b0;
        #1;
        cyc(1, 0, 16'h0, 0, 0);
        cyc(1, 0, 16'h0, 0, 0);
        mon_en = 1;
        @(negedge clk);
        chk("rst_empty", 32'(empty), 32'h1);
        chk("rst_out_data", 32'(out_data), 32'h0);
        #1;

        // Single capture, then hold while the consumer stalls.
        cyc(0, 1, 16'd100, 0, 0);
        @(negedge clk);
        chk("single_data", 32'(out_data), 32'd100);
        #1;
        idle(5);
        chk("single_hold", 32'(out_data), 32'd100);
        drain(1);

        // Ordered drain of a full buffer.
        for (int i = 1; i <= 4; i++) cyc(0, 1, 16'(i), 0, 0);
        chk("fill_full", 32'(full), 32'h1);
        drain(5);

        // Overflow: fifth word dropped, then cleared.
        for (int i = 1; i <= 4; i++) cyc(0, 1, 16'(i * 10), 0, 0);
        cyc(0, 1, 16'd50, 0, 0);
        chk("ovf_set", 32'(overflow), 32'h1);
        chk("ovf_count", 32'(count), 32'd4);
        drain(5);
        cyc(0, 0, 16'h0, 0, 1);
        chk("ovf_clr", 32'(overflow), 32'h0);

        // Simultaneous push and pop while full.
        for (int i = 1; i <= 4; i++) cyc(0, 1, 16'(i * 10), 0, 0);
        cyc(0, 1, 16'd50, 1, 0);
        chk("fullpp_count", 32'(count), 32'd4);
        chk("fullpp_ovf", 32'(overflow), 32'h0);
        chk("fullpp_head", 32'(out_data), 32'd20);
        drain(5);

        // Clear and drop in the same cycle: set wins.
        for (int i = 1; i <= 4; i++) cyc(0, 1, 16'(i), 0, 0);
        cyc(0, 1, 16'h77, 0, 1);
        chk("ovf_set_wins", 32'(overflow), 32'h1);
        drain(5);
        cyc(0, 0, 16'h0, 0, 1);

        // Wrap-around with single push/pop pairs.
        for (int i = 1; i <= 10; i++) begin
            cyc(0, 1, 16'(i), 0, 0);
            cyc(0, 0, 16'h0, 1, 0);
        end

        // Empty plus strobe plus ready: push only.
        cyc(0, 1, 16'h1234, 1, 0);
        chk("empty_push_count", 32'(count), 32'd1);
        drain(2);

        // Reset mid-stream with a strobe on the bus.
        for (int i = 1; i <= 3; i++) cyc(0, 1, 16'(i + 200), 0, 0);
        cyc(0, 1, 16'd5, 0, 0);
        cyc(0, 1, 16'd6, 0, 0);
        cyc(1, 1, 16'hFFFF, 1, 0);
        chk("midrst_count", 32'(count), 32'd0);
        chk("midrst_ovf", 32'(overflow), 32'h0);
        idle(2);

        // Randomized traffic in phases with different consumer duty cycles.
        for (int k = 0; k < 3000; k++) begin
            int phase;
            logic rst_r, l_r, rdy_r, clr_r;
            phase = k / 500;
            rst_r = ($urandom_range(0, 249) == 0);
            l_r   = ($urandom_range(0, 3) != 0);
            case (phase % 3)
                0:       rdy_r = ($urandom_range(0, 3) == 0);
                1:       rdy_r = ($urandom_range(0, 3) != 0);
                default: rdy_r = 1'($urandom_range(0, 1));
            endcase
            clr_r = ($urandom_range(0, 15) == 0);
            cyc(rst_r, l_r, 16'($urandom), rdy_r, clr_r);
        end

        drain(6);
        chk("final_empty", 32'(empty), 32'h1);
        mon_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
